// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder slice.
//   state_e      : controller states
//   size_e       : access size codes driven on the size bus
//   *_DEF        : default geometry and timing parameters
//   access_error : flags reserved sizes and misaligned word/half accesses
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam int unsigned MEM_DEPTH_DEF = 256;
    localparam int unsigned LATENCY_DEF   = 3;

    function automatic logic access_error(input size_e size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_WORD: bad = (off != 2'b00);
            SZ_HALF: bad = off[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and mem_responder.
//   master : drives req, ReadWrite, size, uns, addr, wdata
//   slave  : drives rdata, busy, done, err
interface mem_responder_if;

    logic        req;
    logic        ReadWrite;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output req, ReadWrite, size, uns, addr, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  req, ReadWrite, size, uns, addr, wdata,
        output rdata, busy, done, err
    );

endinterface

// File: rtl/mem_responder_lane_merge.sv
// Combinational byte-lane logic for mem_responder.
//   old_word : current contents of the addressed word
//   wdata    : write data, sub-word values taken from the low bits
//   size     : access size
//   byte_off : addr[1:0] of the access
//   uns      : 1 = zero-extend sub-word reads, 0 = sign-extend
//   rd_val   : extracted and extended read value
//   wr_word  : old_word with only the addressed lanes replaced
module mem_lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  byte_off,
    input  logic        uns,
    output logic [31:0] rd_val,
    output logic [31:0] wr_word
);

    logic [15:0] half_val;
    logic [7:0]  byte_val;

    always_comb begin
        rd_val   = '0;
        wr_word  = old_word;
        half_val = old_word[{byte_off[1], 4'b0000} +: 16];
        byte_val = old_word[{byte_off, 3'b000} +: 8];
        case (size)
            SZ_WORD: begin
                rd_val  = old_word;
                wr_word = wdata;
            end
            SZ_HALF: begin
                rd_val = {{16{~uns & half_val[15]}}, half_val};
                wr_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_BYTE: begin
                rd_val = {{24{~uns & byte_val[7]}}, byte_val};
                wr_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            default: begin
                rd_val  = '0;
                wr_word = old_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder with byte/half/word access.
//   clock : rising-edge clock
//   reset : synchronous active-high reset (array contents are kept)
//   bus   : slave side of mem_responder_if (request in, rdata/busy/done/err out)
// A valid request completes LATENCY clocks after acceptance; an illegal
// size/alignment completes one clock after acceptance with err set.
// LATENCY must be in 2..5 (the WAIT counter is 2 bits).
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int unsigned LATENCY   = LATENCY_DEF
) (
    input  logic            clock,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int unsigned AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0]  WAIT_LAST = 2'(LATENCY - 2);

    state_e         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [AW+1:0]  addr_q, addr_d;
    size_e          size_q, size_d;
    logic           rw_q, rw_d;
    logic           uns_q, uns_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;

    logic [31:0]    mem_array [MEM_DEPTH];
    logic [AW-1:0]  idx;
    logic [31:0]    old_word;
    logic [31:0]    rd_val;
    logic [31:0]    wr_word;
    logic           mem_we;

    assign idx      = addr_q[AW+1:2];
    assign old_word = mem_array[idx];

    mem_lane_merge u_lane_merge (
        .old_word (old_word),
        .wdata    (wdata_q),
        .size     (size_q),
        .byte_off (addr_q[1:0]),
        .uns      (uns_q),
        .rd_val   (rd_val),
        .wr_word  (wr_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        rw_d    = rw_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            // DONE accepts like IDLE so a request seen on the edge that ends
            // the done pulse starts immediately (one transaction per 4 clocks).
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.req) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    addr_d  = bus.addr[AW+1:0];
                    size_d  = size_e'(bus.size);
                    rw_d    = bus.ReadWrite;
                    uns_d   = bus.uns;
                    wdata_d = bus.wdata;
                    err_d   = access_error(size_e'(bus.size), bus.addr[1:0]);
                end
            end
            ST_WAIT: begin
                // Illegal requests leave after one clock, bypassing ACCESS.
                if (err_q) begin
                    state_d = ST_DONE;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                if (rw_q) begin
                    mem_we = 1'b1;
                end else begin
                    rdata_d = rd_val;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= SZ_WORD;
            rw_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is never cleared; reset only suppresses a pending commit.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_array[idx] <= wr_word;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.err   = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    typedef struct packed {
        logic        rw;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  lat;
        logic        er;
        logic [31:0] rd;
    } vec_t;

    localparam int NVEC = 25;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs [NVEC];

    always #5 clock = ~clock;

    mem_responder_if bus ();

    mem_responder #(.MEM_DEPTH(256), .LATENCY(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req       = 1'b1;
        bus.ReadWrite = rw;
        bus.size      = sz;
        bus.uns       = u;
        bus.addr      = a;
        bus.wdata     = wd;
    endtask

    // One transaction: drive at a negedge, accept at the next posedge (E0),
    // then sample at each following negedge k (between E0+k and E0+k+1).
    task automatic txn(input string nm, input vec_t v);
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        drive(v.rw, v.sz, v.u, v.a, v.wd);
        @(posedge clock);
        #1 bus.req = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            if (k == 0) check({nm, ".busy"}, 32'(bus.busy), 32'd1);
            if (bus.done) begin
                seen = 1'b1;
                check({nm, ".latency"}, 32'(k), 32'(v.lat));
                check({nm, ".err"}, 32'(bus.err), 32'(v.er));
                check({nm, ".rdata"}, bus.rdata, v.rd);
            end else begin
                check({nm, ".err_low"}, 32'(bus.err), 32'd0);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got no done, expected done after %0d clocks", nm, v.lat);
        end
    endtask

    initial begin
        int dones;

        vecs = '{
            '{1'b1, 2'b00, 1'b0, 32'h10,  32'hDEADBEEF, 4'd3, 1'b0, 32'h00000000},
            '{1'b0, 2'b00, 1'b0, 32'h10,  32'h0,        4'd3, 1'b0, 32'hDEADBEEF},
            '{1'b1, 2'b10, 1'b0, 32'h11,  32'h0000007F, 4'd3, 1'b0, 32'hDEADBEEF},
            '{1'b0, 2'b00, 1'b0, 32'h10,  32'h0,        4'd3, 1'b0, 32'hDEAD7FEF},
            '{1'b0, 2'b10, 1'b0, 32'h13,  32'h0,        4'd3, 1'b0, 32'hFFFFFFDE},
            '{1'b0, 2'b10, 1'b1, 32'h13,  32'h0,        4'd3, 1'b0, 32'h000000DE},
            '{1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        4'd3, 1'b0, 32'hFFFFDEAD},
            '{1'b0, 2'b01, 1'b0, 32'h11,  32'h0,        4'd1, 1'b1, 32'hFFFFDEAD},
            '{1'b0, 2'b00, 1'b0, 32'h12,  32'h0,        4'd1, 1'b1, 32'hFFFFDEAD},
            '{1'b1, 2'b11, 1'b0, 32'h10,  32'hFFFFFFFF, 4'd1, 1'b1, 32'hFFFFDEAD},
            '{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        4'd1, 1'b1, 32'hFFFFDEAD},
            '{1'b0, 2'b00, 1'b0, 32'h10,  32'h0,        4'd3, 1'b0, 32'hDEAD7FEF},
            '{1'b1, 2'b00, 1'b0, 32'h14,  32'h11223344, 4'd3, 1'b0, 32'hDEAD7FEF},
            '{1'b1, 2'b01, 1'b0, 32'h16,  32'h9999BEEF, 4'd3, 1'b0, 32'hDEAD7FEF},
            '{1'b0, 2'b00, 1'b0, 32'h14,  32'h0,        4'd3, 1'b0, 32'hBEEF3344},
            '{1'b0, 2'b01, 1'b1, 32'h14,  32'h0,        4'd3, 1'b0, 32'h00003344},
            '{1'b0, 2'b01, 1'b0, 32'h16,  32'h0,        4'd3, 1'b0, 32'hFFFFBEEF},
            '{1'b1, 2'b10, 1'b0, 32'h14,  32'h12345680, 4'd3, 1'b0, 32'hFFFFBEEF},
            '{1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        4'd3, 1'b0, 32'hFFFFFF80},
            '{1'b0, 2'b10, 1'b0, 32'h15,  32'h0,        4'd3, 1'b0, 32'h00000033},
            '{1'b0, 2'b00, 1'b0, 32'h14,  32'h0,        4'd3, 1'b0, 32'hBEEF3380},
            '{1'b1, 2'b00, 1'b0, 32'h15,  32'h0,        4'd1, 1'b1, 32'hBEEF3380},
            '{1'b1, 2'b01, 1'b0, 32'h17,  32'h0,        4'd1, 1'b1, 32'hBEEF3380},
            '{1'b0, 2'b00, 1'b0, 32'h14,  32'h0,        4'd3, 1'b0, 32'hBEEF3380},
            '{1'b0, 2'b00, 1'b0, 32'h410, 32'h0,        4'd3, 1'b0, 32'hDEAD7FEF}
        };

        bus.req = 1'b0; bus.ReadWrite = 1'b0; bus.size = 2'b00;
        bus.uns = 1'b0; bus.addr = '0; bus.wdata = '0;

        repeat (3) @(negedge clock);
        check("reset.busy",  32'(bus.busy), 32'd0);
        check("reset.done",  32'(bus.done), 32'd0);
        check("reset.err",   32'(bus.err),  32'd0);
        check("reset.rdata", bus.rdata,     32'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            txn($sformatf("vec%0d", i), vecs[i]);
        end

        // req held high: accepted every 4 clocks, done at k = 3, 7, 11.
        @(negedge clock);
        drive(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        @(posedge clock);
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            check($sformatf("stream.done%0d", k), 32'(bus.done), 32'((k % 4) == 3));
            check($sformatf("stream.busy%0d", k), 32'(bus.busy), 32'd1);
            if (k == 11) bus.req = 1'b0;
        end
        check("stream.rdata", bus.rdata, 32'hDEAD7FEF);
        @(negedge clock);
        check("stream.idle", 32'(bus.busy), 32'd0);

        // req kept high through WAIT/ACCESS with different data: ignored.
        @(negedge clock);
        drive(1'b1, 2'b00, 1'b0, 32'h20, 32'hA5A5A5A5);
        @(posedge clock);
        #1 bus.wdata = 32'hFFFFFFFF;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.done) dones++;
            if (k == 3) bus.req = 1'b0;
        end
        check("pulse.done_count", 32'(dones), 32'd1);
        txn("pulse.readback", '{1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 4'd3, 1'b0, 32'hA5A5A5A5});

        // Reset at E0+2 (with req also high) aborts an in-flight write.
        @(negedge clock);
        drive(1'b1, 2'b00, 1'b0, 32'h20, 32'h12345678);
        @(posedge clock);
        #1 bus.req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        bus.req = 1'b1;
        @(negedge clock);
        check("rst2.busy",  32'(bus.busy), 32'd0);
        check("rst2.done",  32'(bus.done), 32'd0);
        check("rst2.err",   32'(bus.err),  32'd0);
        check("rst2.rdata", bus.rdata,     32'd0);
        reset = 1'b0;
        bus.req = 1'b0;
        dones = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.done) dones++;
        end
        check("rst2.no_done", 32'(dones), 32'd0);
        txn("rst2.readback", '{1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 4'd3, 1'b0, 32'hA5A5A5A5});

        // Reset coinciding with the commit edge E0+3 also blocks the write.
        @(negedge clock);
        drive(1'b1, 2'b00, 1'b0, 32'h20, 32'h55AA55AA);
        @(posedge clock);
        #1 bus.req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst3.busy", 32'(bus.busy), 32'd0);
        check("rst3.done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        txn("rst3.readback", '{1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 4'd3, 1'b0, 32'hA5A5A5A5});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clock.
REQ-002 Port list, in order (name, direction, width, meaning):
- clock  in  1  system clock, all state changes on the rising edge
- reset  in  1  synchronous active-high reset
- req  in  1  request strobe, sampled only in IDLE
- ReadWrite  in  1  0 = read, 1 = write (same polarity as the control unit)
- size  in  2  00 word, 01 half, 10 byte, 11 reserved
- uns  in  1  1 = zero-extend sub-word reads, 0 = sign-extend
- addr  in  32  byte address; word index addr[9:2], addr[31:10] ignored
- wdata  in  32  write data; sub-word data taken from the low bits
- rdata  out  32  read result
- busy  out  1  high from the accepting edge until done falls
- done  out  1  one-cycle completion pulse
- err  out  1  error flag, valid only while done = 1
REQ-003 Parameters (name, default, meaning):
- MEM_DEPTH, 256, words of storage
- LATENCY, 3, clocks from the accepting edge to done

Function
REQ-004 Storage SHALL be MEM_DEPTH x 32 little-endian: byte k = word[8k+7:8k] for addr[1:0] = k; half h = word[16h+15:16h] for addr[1] = h.
REQ-005 States SHALL be IDLE, WAIT, ACCESS and DONE.
- A 2-bit counter sequences the WAIT state.
REQ-006 Acceptance: in IDLE with req = 1 at edge E0, the block SHALL latch addr, size, ReadWrite, uns and wdata, set busy = 1, and enter WAIT with counter = 0.
REQ-007 Requests arriving while busy = 1 SHALL be ignored, with no queuing.
REQ-008 WAIT SHALL last LATENCY-1 = 2 clocks, then move to ACCESS.
REQ-009 ACCESS SHALL last 1 clock, then move to DONE.
REQ-010 ACCESS on a read SHALL load rdata with the extracted, extended value at edge E0+3.
REQ-011 ACCESS on a write SHALL commit to the array at edge E0+3:
- word size writes the full word
- sub-word sizes do a read-modify-write of only the addressed lanes; other lanes are preserved
REQ-012 DONE SHALL hold done = 1 for exactly one clock (from E0+3 to E0+4), then return to IDLE with busy = 0.
- A new req sampled at E0+4 SHALL be accepted.
REQ-013 rdata SHALL hold its value until the next successful read completes; writes and errors SHALL NOT change it.
REQ-014 Error cases:
- size = 11
- half with addr[0] = 1
- word with addr[1:0] != 0
REQ-015 On an error the block SHALL skip WAIT and ACCESS and go directly to DONE at E0+1 with err = 1.
- The array and rdata SHALL be unchanged.
REQ-016 err SHALL be 0 whenever done = 0.
REQ-017 A read and a write to the same word on consecutive transactions SHALL see the committed data, with no stale forwarding.

Reset
REQ-018 On reset the block SHALL enter IDLE with counter = 0, busy = 0, done = 0, err = 0 and rdata = 0.
REQ-019 Reset asserted at or before edge E0+3 of an in-flight write SHALL abort the write with no array change; reset SHALL NOT clear array contents.
REQ-020 Reset SHALL take priority over req on the same edge.

Structure
REQ-021 A shared package mem_pkg SHALL hold:
- the state encoding
- the size codes (SZ_WORD, SZ_HALF, SZ_BYTE)
- MEM_DEPTH and LATENCY defaults
REQ-022 Byte-lane extract/extend and merge logic SHALL be a combinational sub-module, mem_lane_merge, instantiated once.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Word write 0xDEADBEEF to addr 0x10, then word read of 0x10 -> done at E0+3 each, rdata = 0xDEADBEEF, err = 0.
- Byte write 0x7F to addr 0x11 over that word, then word read -> rdata = 0xDEAD7FEF; byte read of 0x13 with uns = 0 -> 0xFFFFFFDE; with uns = 1 -> 0x000000DE.
- Half read of addr 0x12, uns = 0 -> rdata = 0xFFFFDEAD; half read of addr 0x11 -> done at E0+1, err = 1, rdata unchanged.
- req held high continuously -> one acceptance per 4 clocks; req pulsed during busy -> ignored, with exactly one done per accepted request.
- Word write 0x12345678 to addr 0x20 with reset asserted at E0+2, then read of 0x20 -> old contents returned, busy = 0 and done = 0 immediately after the reset edge.
- size = 11 with any address -> err = 1 at E0+1, no array change.
